frame_buffer_multibank: RTL and testbench
=========================================

# frame_buffer_multibank

Multi-bank frame store with independent write and read ports, generalising the single LRAM dual-port frame buffer to 2 or 3 banks with ping-pong (double) or triple buffering. The camera or graphics writer fills a back bank while the display reader scans a front bank. Bank hand-over happens only at frame boundaries, under two pulse handshakes, so the reader never sees a partially written frame. The block sits between the frame writer and the display/readout path, in place of a bare memory instance.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8
- ADDR_WIDTH, 13, word address width per bank; bank depth is 2^ADDR_WIDTH
- NUM_BANKS, 2, 2 (double buffer) or 3 (triple buffer); other values are a fatal elaboration error
- BYTE_WIDTH, DATA_WIDTH/8, byte-enable width

Ports:
- clk_i  in  1  single clock for both ports
- rst_i  in  1  asynchronous, active-high reset
- wr_en_i  in  1  write strobe
- wr_addr_i  in  ADDR_WIDTH  word address within the write bank
- wr_data_i  in  DATA_WIDTH  write data
- ben_i  in  BYTE_WIDTH  byte enables; bit n gates byte n
- wr_frame_done_i  in  1  pulse: the write bank holds a complete frame
- wr_stall_o  out  1  no free bank; writes and wr_frame_done_i are ignored
- rd_en_i  in  1  read strobe
- rd_addr_i  in  ADDR_WIDTH  word address within the read bank
- rd_frame_start_i  in  1  pulse: the reader begins a new frame
- rd_data_o  out  DATA_WIDTH  read data
- rd_datavalid_o  out  1  rd_data_o is valid this cycle
- wr_bank_o  out  2  current write bank index
- rd_bank_o  out  2  current read bank index
- frame_ready_o  out  1  a completed frame is waiting for the reader
- drop_o  out  1  one-cycle pulse: an undisplayed ready frame was discarded (NUM_BANKS=3 only)
- repeat_o  out  1  one-cycle pulse: rd_frame_start_i arrived with no ready frame; the reader repeats its current bank

## Operation
- Storage is NUM_BANKS×2^ADDR_WIDTH words, addressed as {bank, addr}. The memory array is not reset.
- Bank state registers:
  - rd_bank
  - wr_bank
  - ready_bank
  - ready_valid (drives frame_ready_o)
  - stall (drives wr_stall_o)
- Invariant: wr_bank ≠ rd_bank whenever stall=0. Read/write collisions on the same bank therefore cannot occur.
- Write: when wr_en_i=1 and stall=0, the enabled bytes of wr_data_i go to {wr_bank, wr_addr_i}.
- Read: when rd_en_i=1, {rd_bank, rd_addr_i} is read; rd_datavalid_o follows after the read latency.
- wr_frame_done_i (when stall=0):
  - Old ready_valid=1 (NUM_BANKS=3 only): the previous ready bank is freed and drop_o pulses.
  - ready_bank←wr_bank, ready_valid←1.
  - wr_bank← lowest-index bank that is neither rd_bank nor the new ready_bank.
  - NUM_BANKS=2: no such bank exists, so stall←1 and wr_bank is held.
- rd_frame_start_i:
  - ready_valid=1: rd_bank←ready_bank, ready_valid←0, and the old rd_bank becomes free. If stall=1, then wr_bank←old rd_bank and stall←0.
  - ready_valid=0: rd_bank is unchanged and repeat_o pulses.
- Both pulses in the same cycle: apply wr_frame_done_i first, then rd_frame_start_i, within that one cycle.
  - The reader receives the just-completed bank.
  - The writer receives the lowest-index free bank.
  - With NUM_BANKS=3 and an older frame pending, drop_o pulses.
- rst_i: rd_bank=0, wr_bank=1, ready_bank=0, ready_valid=0, stall=0. Any in-flight read is cancelled (rd_datavalid_o=0).

## Timing
- All bank switches take effect on the cycle after the pulse. A write or read in the same cycle as its frame pulse uses the old bank.
- Read latency: 1 cycle from rd_en_i to rd_datavalid_o/rd_data_o (2 cycles with FRAME_BUFFER_REGOUT_EN).
- rd_data_o holds its last value when rd_datavalid_o=0.
- Output reset values:
  - 0: rd_data_o, rd_datavalid_o, frame_ready_o, wr_stall_o, drop_o, repeat_o, rd_bank_o
  - 1: wr_bank_o
- Reads and writes are fully pipelined, at 1 word per cycle per port.
- Status outputs are registered and update in the cycle after the causing pulse.

## Configuration
- FRAME_BUFFER_REGOUT_EN
  - Defined: adds an output register stage; read latency is 2 and the rd_data_o/rd_datavalid_o path is retimed.
  - Undefined: read latency is 1.
- Bank logic is identical in both builds.

## Test plan
- Reset, then write 0xA5A5_0001 at address 3 with ben=4'hF, pulse wr_frame_done_i, pulse rd_frame_start_i, read address 3 → rd_data_o=0xA5A5_0001 after 1 cycle (2 with REGOUT), rd_bank_o=1, wr_bank_o=0.
- NUM_BANKS=2: pulse wr_frame_done_i twice without rd_frame_start_i → wr_stall_o=1 after the first pulse; the second pulse and all writes are ignored. A later rd_frame_start_i clears the stall and gives wr_bank_o=0.
- NUM_BANKS=3: pulse wr_frame_done_i twice → drop_o pulses once. rd_frame_start_i then selects the second completed bank.
- Byte enables: write 0xFFFF_FFFF, then 0x1234_5678 with ben=4'b0101 → reads back 0xFF34_FF78.
- rd_frame_start_i with frame_ready_o=0 → repeat_o pulses and rd_bank_o is unchanged. Same-cycle done+start → the reader gets the just-completed bank.
- Assert rst_i while a read is in flight → rd_datavalid_o=0 immediately and bank indices return to their reset values.

Source files
------------

// File: rtl/frame_buffer_multibank_if.sv
`default_nettype none
// ============================================================================
//  Module  : frame_buffer_multibank_if
//  Purpose : Bus bundle for frame_buffer_multibank: write port, read port,
//            frame hand-over pulses and bank status.
//  Ports   : master modport = writer/reader side (drives *_i, samples *_o)
//            slave  modport = frame buffer side  (samples *_i, drives *_o)
//  Rev     : 1.0  initial release
// ============================================================================
interface frame_buffer_multibank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 13,
   parameter int BYTE_WIDTH = DATA_WIDTH / 8
);
   logic                  wr_en_i;
   logic [ADDR_WIDTH-1:0] wr_addr_i;
   logic [DATA_WIDTH-1:0] wr_data_i;
   logic [BYTE_WIDTH-1:0] ben_i;
   logic                  wr_frame_done_i;
   logic                  wr_stall_o;
   logic                  rd_en_i;
   logic [ADDR_WIDTH-1:0] rd_addr_i;
   logic                  rd_frame_start_i;
   logic [DATA_WIDTH-1:0] rd_data_o;
   logic                  rd_datavalid_o;
   logic [1:0]            wr_bank_o;
   logic [1:0]            rd_bank_o;
   logic                  frame_ready_o;
   logic                  drop_o;
   logic                  repeat_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, ben_i, wr_frame_done_i,
      output rd_en_i, rd_addr_i, rd_frame_start_i,
      input  wr_stall_o, rd_data_o, rd_datavalid_o, wr_bank_o, rd_bank_o,
      input  frame_ready_o, drop_o, repeat_o
   );

   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, ben_i, wr_frame_done_i,
      input  rd_en_i, rd_addr_i, rd_frame_start_i,
      output wr_stall_o, rd_data_o, rd_datavalid_o, wr_bank_o, rd_bank_o,
      output frame_ready_o, drop_o, repeat_o
   );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_multibank.sv
`default_nettype none
// ============================================================================
//  Module  : frame_buffer_multibank
//  Purpose : 2- or 3-bank frame store (double / triple buffering). The writer
//            fills a back bank while the reader scans the front bank; banks
//            change hands only on wr_frame_done_i / rd_frame_start_i pulses.
//  Ports   : clk_i  - single clock for both ports
//            rst_i  - asynchronous active-high reset
//            fb_if  - slave modport: write port, read port, frame pulses,
//                     bank indices and frame status outputs
//  Config  : FRAME_BUFFER_REGOUT_EN - adds a read output register stage
//            (read latency 2 instead of 1).
//  Rev     : 1.0  initial release
// ============================================================================
module frame_buffer_multibank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 13,
   parameter int NUM_BANKS  = 2,
   parameter int BYTE_WIDTH = DATA_WIDTH / 8
) (
   input  wire logic               clk_i,
   input  wire logic               rst_i,
   frame_buffer_multibank_if.slave fb_if
);

   localparam int DEPTH = NUM_BANKS << ADDR_WIDTH;
   localparam int IDX_W = $clog2(DEPTH);

   generate
      if (NUM_BANKS != 2 && NUM_BANKS != 3) begin : g_bad_banks
         $fatal(1, "frame_buffer_multibank: NUM_BANKS must be 2 or 3");
      end
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
         $fatal(1, "frame_buffer_multibank: DATA_WIDTH must be a multiple of 8");
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Bank bookkeeping
   // ---------------------------------------------------------------------
   logic [1:0] rd_bank_q, rd_bank_d;
   logic [1:0] wr_bank_q, wr_bank_d;
   logic [1:0] ready_bank_q, ready_bank_d;
   logic       ready_valid_q, ready_valid_d;
   logic       stall_q, stall_d;
   logic       drop_q, drop_d;
   logic       repeat_q, repeat_d;
   logic       found;

   // Frame-done is resolved first, then frame-start sees its result, so a
   // same-cycle pair hands the just-completed bank straight to the reader.
   always_comb begin
      rd_bank_d     = rd_bank_q;
      wr_bank_d     = wr_bank_q;
      ready_bank_d  = ready_bank_q;
      ready_valid_d = ready_valid_q;
      stall_d       = stall_q;
      drop_d        = 1'b0;
      repeat_d      = 1'b0;
      found         = 1'b0;

      if (fb_if.wr_frame_done_i && !stall_q) begin
         // A pending frame that is overwritten as "ready" is dropped; its
         // bank becomes free again (only reachable with three banks).
         drop_d        = ready_valid_q && (NUM_BANKS == 3);
         ready_bank_d  = wr_bank_q;
         ready_valid_d = 1'b1;
         // Descending scan so the lowest free index wins.
         for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (2'(b) != rd_bank_q && 2'(b) != wr_bank_q) begin
               wr_bank_d = 2'(b);
               found     = 1'b1;
            end
         end
         if (!found) begin
            stall_d = 1'b1;
         end
      end

      if (fb_if.rd_frame_start_i) begin
         if (ready_valid_d) begin
            rd_bank_d     = ready_bank_d;
            ready_valid_d = 1'b0;
            // The stalled writer inherits the bank the reader just left.
            if (stall_d) begin
               wr_bank_d = rd_bank_q;
               stall_d   = 1'b0;
            end
         end else begin
            repeat_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_bank_q     <= 2'd0;
         wr_bank_q     <= 2'd1;
         ready_bank_q  <= 2'd0;
         ready_valid_q <= 1'b0;
         stall_q       <= 1'b0;
         drop_q        <= 1'b0;
         repeat_q      <= 1'b0;
      end else begin
         rd_bank_q     <= rd_bank_d;
         wr_bank_q     <= wr_bank_d;
         ready_bank_q  <= ready_bank_d;
         ready_valid_q <= ready_valid_d;
         stall_q       <= stall_d;
         drop_q        <= drop_d;
         repeat_q      <= repeat_d;
      end
   end

   // ---------------------------------------------------------------------
   // Storage: flat array addressed as {bank, addr}; bank index never
   // exceeds NUM_BANKS-1, so truncating to IDX_W bits is lossless.
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;

   assign wr_idx = IDX_W'({wr_bank_q, fb_if.wr_addr_i});
   assign rd_idx = IDX_W'({rd_bank_q, fb_if.rd_addr_i});

   always_ff @(posedge clk_i) begin
      if (fb_if.wr_en_i && !stall_q) begin
         for (int b = 0; b < BYTE_WIDTH; b++) begin
            if (fb_if.ben_i[b]) begin
               mem_q[wr_idx][8*b +: 8] <= fb_if.wr_data_i[8*b +: 8];
            end
         end
      end
   end

   // Read stage 1: data register only loads on a read so it holds otherwise.
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= fb_if.rd_en_i;
         if (fb_if.rd_en_i) begin
            rd_data_q <= mem_q[rd_idx];
         end
      end
   end

`ifdef FRAME_BUFFER_REGOUT_EN
   logic [DATA_WIDTH-1:0] rd_data2_q;
   logic                  rd_valid2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data2_q  <= '0;
         rd_valid2_q <= 1'b0;
      end else begin
         rd_valid2_q <= rd_valid_q;
         if (rd_valid_q) begin
            rd_data2_q <= rd_data_q;
         end
      end
   end

   assign fb_if.rd_data_o      = rd_data2_q;
   assign fb_if.rd_datavalid_o = rd_valid2_q;
`else
   assign fb_if.rd_data_o      = rd_data_q;
   assign fb_if.rd_datavalid_o = rd_valid_q;
`endif

   assign fb_if.wr_stall_o    = stall_q;
   assign fb_if.wr_bank_o     = wr_bank_q;
   assign fb_if.rd_bank_o     = rd_bank_q;
   assign fb_if.frame_ready_o = ready_valid_q;
   assign fb_if.drop_o        = drop_q;
   assign fb_if.repeat_o      = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_multibank.sv
`default_nettype none
// ============================================================================
//  Module  : tb_frame_buffer_multibank
//  Purpose : Directed bench driving a double-buffer (fb2) and a triple-buffer
//            (fb3) instance with identical stimulus and checking each against
//            hand-computed bank sequences and read data.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_frame_buffer_multibank;

`ifdef FRAME_BUFFER_REGOUT_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk_i = ~clk_i;

   frame_buffer_multibank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) fb2 ();
   frame_buffer_multibank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) fb3 ();

   frame_buffer_multibank #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .NUM_BANKS(2))
      u_dut2 (.clk_i(clk_i), .rst_i(rst_i), .fb_if(fb2));
   frame_buffer_multibank #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .NUM_BANKS(3))
      u_dut3 (.clk_i(clk_i), .rst_i(rst_i), .fb_if(fb3));

   assign fb3.wr_en_i          = fb2.wr_en_i;
   assign fb3.wr_addr_i        = fb2.wr_addr_i;
   assign fb3.wr_data_i        = fb2.wr_data_i;
   assign fb3.ben_i            = fb2.ben_i;
   assign fb3.wr_frame_done_i  = fb2.wr_frame_done_i;
   assign fb3.rd_en_i          = fb2.rd_en_i;
   assign fb3.rd_addr_i        = fb2.rd_addr_i;
   assign fb3.rd_frame_start_i = fb2.rd_frame_start_i;

   typedef struct {
      logic [12:0] addr;
      logic [31:0] data;
      logic [3:0]  ben;
      logic [31:0] exp;
      logic [1:0]  rd2;
      logic [1:0]  rd3;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] b);
      fb2.wr_en_i   = 1'b1;
      fb2.wr_addr_i = a;
      fb2.wr_data_i = d;
      fb2.ben_i     = b;
      step();
      fb2.wr_en_i   = 1'b0;
   endtask

   task automatic pulse(input logic done, input logic start);
      fb2.wr_frame_done_i  = done;
      fb2.rd_frame_start_i = start;
      step();
      fb2.wr_frame_done_i  = 1'b0;
      fb2.rd_frame_start_i = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [12:0] a,
                          input logic [31:0] exp2, input logic [31:0] exp3);
      fb2.rd_en_i   = 1'b1;
      fb2.rd_addr_i = a;
      step();
      fb2.rd_en_i   = 1'b0;
      for (int i = 1; i < RD_LAT; i++) step();
      chk({name, " valid2"}, 32'(fb2.rd_datavalid_o), 32'd1);
      chk({name, " data2"},  fb2.rd_data_o, exp2);
      chk({name, " valid3"}, 32'(fb3.rd_datavalid_o), 32'd1);
      chk({name, " data3"},  fb3.rd_data_o, exp3);
   endtask

   initial begin
      vecs[0] = '{addr: 13'd10,   data: 32'h1234_5678, ben: 4'b0101, exp: 32'hFF34_FF78, rd2: 2'd1, rd3: 2'd1};
      vecs[1] = '{addr: 13'd11,   data: 32'h0000_0000, ben: 4'b1000, exp: 32'h00FF_FFFF, rd2: 2'd0, rd3: 2'd2};
      vecs[2] = '{addr: 13'd12,   data: 32'hCAFE_BABE, ben: 4'b0000, exp: 32'hFFFF_FFFF, rd2: 2'd1, rd3: 2'd0};
      vecs[3] = '{addr: 13'd13,   data: 32'hDEAD_BEEF, ben: 4'b1111, exp: 32'hDEAD_BEEF, rd2: 2'd0, rd3: 2'd1};
      vecs[4] = '{addr: 13'd8191, data: 32'h0000_ABCD, ben: 4'b0011, exp: 32'hFFFF_ABCD, rd2: 2'd1, rd3: 2'd2};

      fb2.wr_en_i = 1'b0; fb2.wr_addr_i = '0; fb2.wr_data_i = '0; fb2.ben_i = '0;
      fb2.wr_frame_done_i = 1'b0; fb2.rd_en_i = 1'b0; fb2.rd_addr_i = '0;
      fb2.rd_frame_start_i = 1'b0;
      rst_i = 1'b1;
      step();
      step();

      // Reset values
      chk("rst rd_data",   fb2.rd_data_o, 32'h0);
      chk("rst valid",     32'(fb2.rd_datavalid_o), 32'd0);
      chk("rst rd_bank",   32'(fb2.rd_bank_o), 32'd0);
      chk("rst wr_bank",   32'(fb2.wr_bank_o), 32'd1);
      chk("rst status",    32'({fb2.frame_ready_o, fb2.wr_stall_o, fb2.drop_o, fb2.repeat_o}), 32'd0);
      chk("rst wr_bank3",  32'(fb3.wr_bank_o), 32'd1);
      rst_i = 1'b0;
      step();

      // Basic frame hand-over
      do_write(13'd3, 32'hA5A5_0001, 4'hF);
      pulse(1'b1, 1'b0);
      chk("t1 stall2",  32'(fb2.wr_stall_o), 32'd1);
      chk("t1 ready2",  32'(fb2.frame_ready_o), 32'd1);
      chk("t1 wr3",     32'(fb3.wr_bank_o), 32'd2);
      chk("t1 stall3",  32'(fb3.wr_stall_o), 32'd0);
      pulse(1'b0, 1'b1);
      chk("t1 rd2",     32'(fb2.rd_bank_o), 32'd1);
      chk("t1 wr2",     32'(fb2.wr_bank_o), 32'd0);
      chk("t1 unstall", 32'(fb2.wr_stall_o), 32'd0);
      chk("t1 rd3",     32'(fb3.rd_bank_o), 32'd1);
      do_read("t1 read", 13'd3, 32'hA5A5_0001, 32'hA5A5_0001);
      step();
      chk("t1 hold valid", 32'(fb2.rd_datavalid_o), 32'd0);
      chk("t1 hold data",  fb2.rd_data_o, 32'hA5A5_0001);

      // Two frame-done pulses: stall on 2 banks, drop on 3 banks
      do_write(13'd5, 32'h1111_1111, 4'hF);
      pulse(1'b1, 1'b0);
      chk("t2 wr3", 32'(fb3.wr_bank_o), 32'd0);
      do_write(13'd5, 32'h2222_2222, 4'hF);
      pulse(1'b1, 1'b0);
      chk("t2 drop3",   32'(fb3.drop_o), 32'd1);
      chk("t2 drop2",   32'(fb2.drop_o), 32'd0);
      chk("t2 stall2",  32'(fb2.wr_stall_o), 32'd1);
      chk("t2 wr2",     32'(fb2.wr_bank_o), 32'd0);
      step();
      chk("t2 drop3 end", 32'(fb3.drop_o), 32'd0);
      pulse(1'b0, 1'b1);
      chk("t2 rd2", 32'(fb2.rd_bank_o), 32'd0);
      chk("t2 wr2 after", 32'(fb2.wr_bank_o), 32'd1);
      chk("t2 rd3", 32'(fb3.rd_bank_o), 32'd0);
      chk("t2 wr3 after", 32'(fb3.wr_bank_o), 32'd2);
      do_read("t2 read", 13'd5, 32'h1111_1111, 32'h2222_2222);

      // Frame start with nothing ready
      pulse(1'b0, 1'b1);
      chk("t3 repeat2", 32'(fb2.repeat_o), 32'd1);
      chk("t3 repeat3", 32'(fb3.repeat_o), 32'd1);
      chk("t3 rd2",     32'(fb2.rd_bank_o), 32'd0);
      chk("t3 rd3",     32'(fb3.rd_bank_o), 32'd0);
      step();
      chk("t3 repeat end", 32'(fb2.repeat_o), 32'd0);

      // Same-cycle done + start
      do_write(13'd7, 32'h3333_3333, 4'hF);
      pulse(1'b1, 1'b1);
      chk("t4 rd2",    32'(fb2.rd_bank_o), 32'd1);
      chk("t4 wr2",    32'(fb2.wr_bank_o), 32'd0);
      chk("t4 stat2",  32'({fb2.wr_stall_o, fb2.frame_ready_o, fb2.repeat_o}), 32'd0);
      chk("t4 rd3",    32'(fb3.rd_bank_o), 32'd2);
      chk("t4 wr3",    32'(fb3.wr_bank_o), 32'd1);
      do_read("t4 read", 13'd7, 32'h3333_3333, 32'h3333_3333);

      // Same-cycle done + start with an older frame pending
      do_write(13'd8, 32'h4444_4444, 4'hF);
      pulse(1'b1, 1'b0);
      do_write(13'd8, 32'h5555_5555, 4'hF);
      pulse(1'b1, 1'b1);
      chk("t4b drop3", 32'(fb3.drop_o), 32'd1);
      chk("t4b rd3",   32'(fb3.rd_bank_o), 32'd0);
      chk("t4b wr3",   32'(fb3.wr_bank_o), 32'd1);
      chk("t4b rd2",   32'(fb2.rd_bank_o), 32'd0);
      chk("t4b wr2",   32'(fb2.wr_bank_o), 32'd1);
      do_read("t4b read", 13'd8, 32'h4444_4444, 32'h5555_5555);

      // Byte-enable table
      for (int i = 0; i < 5; i++) begin
         do_write(vecs[i].addr, 32'hFFFF_FFFF, 4'hF);
         do_write(vecs[i].addr, vecs[i].data, vecs[i].ben);
         pulse(1'b1, 1'b1);
         chk($sformatf("vec%0d rd2", i), 32'(fb2.rd_bank_o), 32'(vecs[i].rd2));
         chk($sformatf("vec%0d rd3", i), 32'(fb3.rd_bank_o), 32'(vecs[i].rd3));
         do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp, vecs[i].exp);
      end

      // Reset with a read in flight
      fb2.rd_en_i   = 1'b1;
      fb2.rd_addr_i = 13'd13;
      for (int i = 0; i < RD_LAT; i++) step();
      chk("t6 valid before", 32'(fb2.rd_datavalid_o), 32'd1);
      rst_i = 1'b1;
      #1;
      chk("t6 valid2", 32'(fb2.rd_datavalid_o), 32'd0);
      chk("t6 valid3", 32'(fb3.rd_datavalid_o), 32'd0);
      chk("t6 data2",  fb2.rd_data_o, 32'h0);
      chk("t6 rd2",    32'(fb2.rd_bank_o), 32'd0);
      chk("t6 wr2",    32'(fb2.wr_bank_o), 32'd1);
      chk("t6 rd3",    32'(fb3.rd_bank_o), 32'd0);
      chk("t6 wr3",    32'(fb3.wr_bank_o), 32'd1);
      fb2.rd_en_i = 1'b0;
      step();
      rst_i = 1'b0;
      step();

      // From reset: two dones, then a start
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      chk("t7 stall2", 32'(fb2.wr_stall_o), 32'd1);
      chk("t7 drop3",  32'(fb3.drop_o), 32'd1);
      pulse(1'b0, 1'b1);
      chk("t7 rd2",    32'(fb2.rd_bank_o), 32'd1);
      chk("t7 wr2",    32'(fb2.wr_bank_o), 32'd0);
      chk("t7 stall2 clr", 32'(fb2.wr_stall_o), 32'd0);
      chk("t7 rd3",    32'(fb3.rd_bank_o), 32'd2);
      chk("t7 wr3",    32'(fb3.wr_bank_o), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
